regfile_wb_scheduler: RTL and testbench

//  Sequences the single write port of the 16x16 register file (16 regs, 2 read, 1 write, write->read bypass).
//  - After reset, or on request, clears every register to 0x0000.
//  - Arbitrates two writeback requesters, ALU and MEM, onto the write port.
//  - Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wb_scheduler_arb.sv | 45 ++++
 rtl/regfile_wb_scheduler.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler.
package regfile_pkg;

    localparam int unsigned RF_AW    = 4;
    localparam int unsigned RF_DW    = 16;
    localparam int unsigned RF_NREGS = 16;

    // Scheduler phases: clearing the file, then normal writeback.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Writeback source ids, also used as the round-robin pointer value.
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_scheduler_arb.sv
// Two-way ALU/MEM arbiter: round-robin on contention, or MEM-first when FIXED_PRIO is set.
module wb_rr_arb2
    import regfile_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    logic rr_ptr;

    // Same-cycle grant; the pointer only matters when both sources request.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (en) begin
            if (req_alu && req_mem) begin
                if ((FIXED_PRIO != 0) || (rr_ptr == SRC_MEM)) begin
                    gnt_mem = 1'b1;
                end else begin
                    gnt_alu = 1'b1;
                end
            end else begin
                gnt_alu = req_alu;
                gnt_mem = req_mem;
            end
        end
    end

    // Pointer moves to the loser after a contested grant only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SRC_ALU;
        end else if (en && req_alu && req_mem) begin
            rr_ptr <= gnt_alu ? SRC_MEM : SRC_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port sequencer for the register file: clear sequence, ALU/MEM arbitration, hazard scoreboard.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS       = RF_NREGS,
    parameter int unsigned AW          = RF_AW,
    parameter int unsigned DW          = RF_DW,
    parameter int unsigned R0_WRITABLE = 1,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_start,
    output logic             busy,
    input  logic             alu_req,
    input  logic [AW-1:0]    alu_reg,
    input  logic [DW-1:0]    alu_data,
    output logic             alu_gnt,
    input  logic             mem_req,
    input  logic [AW-1:0]    mem_reg,
    input  logic [DW-1:0]    mem_data,
    output logic             mem_gnt,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_reg,
    input  logic [AW-1:0]    src1,
    input  logic [AW-1:0]    src2,
    output logic             stall,
    output logic [NREGS-1:0] pending,
    output logic             rf_we,
    output logic [AW-1:0]    rf_dst,
    output logic [DW-1:0]    rf_data
);

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [NREGS-1:0]  pending_q;
    logic [AW-1:0]     last_dst;
    logic [DW-1:0]     last_data;
    logic              arb_en;
    logic              any_gnt;
    logic [AW-1:0]     sel_reg;
    logic [DW-1:0]     sel_data;
    logic [NREGS-1:0]  set_vec;
    logic [NREGS-1:0]  clr_vec;

    // A register is a hazard only if its pending write is not landing this cycle.
    function automatic logic hz(input logic [NREGS-1:0] p, input logic we,
                                input logic [AW-1:0] dst, input logic [AW-1:0] r);
        return p[r] & ~(we && (dst == r));
    endfunction

    // Grants are suppressed outside RUN and in any cycle that restarts the clear.
    assign arb_en = (state == ST_RUN) && !rst && !init_start;

    wb_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en),
        .req_alu (alu_req),
        .req_mem (mem_req),
        .gnt_alu (alu_gnt),
        .gnt_mem (mem_gnt)
    );

    assign busy    = (state == ST_INIT);
    assign pending = pending_q;

    // Write-port mux: clear walk, granted source, or idle hold.
    always_comb begin
        any_gnt  = alu_gnt | mem_gnt;
        sel_reg  = mem_gnt ? mem_reg  : alu_reg;
        sel_data = mem_gnt ? mem_data : alu_data;
        rf_we    = 1'b0;
        rf_dst   = last_dst;
        rf_data  = last_data;
        if (state == ST_INIT) begin
            rf_we   = 1'b1;
            rf_dst  = cnt;
            rf_data = '0;
        end else if (any_gnt) begin
            rf_we   = (R0_WRITABLE != 0) || (sel_reg != '0);
            rf_dst  = sel_reg;
            rf_data = sel_data;
        end
    end

    // Decode stall and scoreboard update vectors.
    always_comb begin
        stall   = busy | hz(pending_q, rf_we, rf_dst, src1) | hz(pending_q, rf_we, rf_dst, src2)
                | (issue_valid & hz(pending_q, rf_we, rf_dst, issue_reg));
        set_vec = (issue_valid && !stall) ? (NREGS'(1) << issue_reg) : '0;
        clr_vec = any_gnt ? (NREGS'(1) << sel_reg) : '0;
    end

    // Phase FSM and clear counter; init_start restarts only from RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (init_start) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Scoreboard: set on issue beats clear on writeback for the same register.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_INIT) || init_start) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_vec) | set_vec;
        end
    end

    // Remember the last driven destination/data so an idle port holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dst  <= '0;
            last_data <= '0;
        end else begin
            last_dst  <= rf_dst;
            last_data <= rf_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: instance a uses defaults, instance b uses FIXED_PRIO=1, R0_WRITABLE=0.
module tb_regfile_wb_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_init_start, a_alu_req, a_mem_req, a_issue_valid;
    logic [3:0]  a_alu_reg, a_mem_reg, a_issue_reg, a_src1, a_src2;
    logic [15:0] a_alu_data, a_mem_data;
    logic        a_busy, a_alu_gnt, a_mem_gnt, a_stall, a_rf_we;
    logic [15:0] a_pending, a_rf_data;
    logic [3:0]  a_rf_dst;

    logic        b_init_start, b_alu_req, b_mem_req, b_issue_valid;
    logic [3:0]  b_alu_reg, b_mem_reg, b_issue_reg, b_src1, b_src2;
    logic [15:0] b_alu_data, b_mem_data;
    logic        b_busy, b_alu_gnt, b_mem_gnt, b_stall, b_rf_we;
    logic [15:0] b_pending, b_rf_data;
    logic [3:0]  b_rf_dst;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler u_a (
        .clk(clk), .rst(rst), .init_start(a_init_start), .busy(a_busy),
        .alu_req(a_alu_req), .alu_reg(a_alu_reg), .alu_data(a_alu_data), .alu_gnt(a_alu_gnt),
        .mem_req(a_mem_req), .mem_reg(a_mem_reg), .mem_data(a_mem_data), .mem_gnt(a_mem_gnt),
        .issue_valid(a_issue_valid), .issue_reg(a_issue_reg), .src1(a_src1), .src2(a_src2),
        .stall(a_stall), .pending(a_pending), .rf_we(a_rf_we), .rf_dst(a_rf_dst), .rf_data(a_rf_data)
    );

    regfile_wb_scheduler #(.R0_WRITABLE(0), .FIXED_PRIO(1)) u_b (
        .clk(clk), .rst(rst), .init_start(b_init_start), .busy(b_busy),
        .alu_req(b_alu_req), .alu_reg(b_alu_reg), .alu_data(b_alu_data), .alu_gnt(b_alu_gnt),
        .mem_req(b_mem_req), .mem_reg(b_mem_reg), .mem_data(b_mem_data), .mem_gnt(b_mem_gnt),
        .issue_valid(b_issue_valid), .issue_reg(b_issue_reg), .src1(b_src1), .src2(b_src2),
        .stall(b_stall), .pending(b_pending), .rf_we(b_rf_we), .rf_dst(b_rf_dst), .rf_data(b_rf_data)
    );

    // Register file models: capture the port mid-cycle, write at the following edge.
    logic [15:0] a_rf [16];
    logic [15:0] b_rf [16];
    logic        a_lw, b_lw;
    logic [3:0]  a_ld, b_ld;
    logic [15:0] a_ldat, b_ldat;

    always @(negedge clk) begin
        a_lw = a_rf_we; a_ld = a_rf_dst; a_ldat = a_rf_data;
        b_lw = b_rf_we; b_ld = b_rf_dst; b_ldat = b_rf_data;
    end

    always @(posedge clk) begin
        if (a_lw === 1'b1) a_rf[a_ld] <= a_ldat;
        if (b_lw === 1'b1) b_rf[b_ld] <= b_ldat;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_init_start = 0; a_alu_req = 0; a_mem_req = 0; a_issue_valid = 0;
        a_alu_reg = 0; a_mem_reg = 0; a_issue_reg = 0; a_src1 = 0; a_src2 = 0;
        a_alu_data = 0; a_mem_data = 0;
        b_init_start = 0; b_alu_req = 0; b_mem_req = 0; b_issue_valid = 0;
        b_alu_reg = 0; b_mem_reg = 0; b_issue_reg = 0; b_src1 = 0; b_src2 = 0;
        b_alu_data = 0; b_mem_data = 0;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy[%0d]: got %b exp 1", i, a_busy); end
            checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL reset_stall[%0d]: got %b exp 1", i, a_stall); end
            checks++; if ({a_alu_gnt, a_mem_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt[%0d]: got %b exp 00", i, {a_alu_gnt, a_mem_gnt}); end
            checks++; if (a_rf_we !== 1'b1) begin errors++; $display("FAIL reset_we[%0d]: got %b exp 1", i, a_rf_we); end
            checks++; if (a_rf_dst !== 4'(i)) begin errors++; $display("FAIL reset_dst[%0d]: got %0d exp %0d", i, a_rf_dst, i); end
            checks++; if (a_rf_data !== 16'h0000) begin errors++; $display("FAIL reset_data[%0d]: got %h exp 0000", i, a_rf_data); end
            checks++; if (b_rf_dst !== 4'(i)) begin errors++; $display("FAIL reset_b_dst[%0d]: got %0d exp %0d", i, b_rf_dst, i); end
            checks++; if (a_pending !== 16'h0000) begin errors++; $display("FAIL reset_pend[%0d]: got %h exp 0000", i, a_pending); end
            tick();
        end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL run_busy: got %b exp 0", a_busy); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL run_b_busy: got %b exp 0", b_busy); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL run_stall: got %b exp 0", a_stall); end
        checks++; if (a_pending !== 16'h0000) begin errors++; $display("FAIL run_pend: got %h exp 0000", a_pending); end
        for (int r = 0; r < 16; r++) begin
            checks++; if (a_rf[r] !== 16'h0000) begin errors++; $display("FAIL clear_a_R%0d: got %h exp 0000", r, a_rf[r]); end
            checks++; if (b_rf[r] !== 16'h0000) begin errors++; $display("FAIL clear_b_R%0d: got %h exp 0000", r, b_rf[r]); end
        end
    endtask

    task automatic test_single_alu();
        a_alu_req = 1; a_alu_reg = 4'd3; a_alu_data = 16'h1234;
        #1;
        checks++; if ({a_alu_gnt, a_mem_gnt} !== 2'b10) begin errors++; $display("FAIL alu_gnt: got %b exp 10", {a_alu_gnt, a_mem_gnt}); end
        checks++; if (a_rf_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %b exp 1", a_rf_we); end
        checks++; if (a_rf_dst !== 4'd3) begin errors++; $display("FAIL alu_dst: got %0d exp 3", a_rf_dst); end
        checks++; if (a_rf_data !== 16'h1234) begin errors++; $display("FAIL alu_data: got %h exp 1234", a_rf_data); end
        tick();
        a_alu_req = 0;
        #1;
        checks++; if (a_rf_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b exp 0", a_rf_we); end
        checks++; if (a_rf_dst !== 4'd3) begin errors++; $display("FAIL idle_dst_hold: got %0d exp 3", a_rf_dst); end
        checks++; if (a_rf_data !== 16'h1234) begin errors++; $display("FAIL idle_data_hold: got %h exp 1234", a_rf_data); end
        checks++; if (a_rf[3] !== 16'h1234) begin errors++; $display("FAIL file_R3: got %h exp 1234", a_rf[3]); end
        tick();
    endtask

    task automatic test_rr_arb();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        a_alu_req = 1; a_alu_reg = 4'd1; a_alu_data = 16'hAAAA;
        a_mem_req = 1; a_mem_reg = 4'd2; a_mem_data = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({a_alu_gnt, a_mem_gnt} !== exp_g[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b exp %b", i, {a_alu_gnt, a_mem_gnt}, exp_g[i]); end
            checks++; if (a_rf_dst !== (exp_g[i][1] ? 4'd1 : 4'd2)) begin errors++; $display("FAIL rr_dst[%0d]: got %0d", i, a_rf_dst); end
            tick();
        end
        a_alu_req = 0; a_mem_req = 0;
        #1;
        checks++; if (a_rf[1] !== 16'hAAAA) begin errors++; $display("FAIL rr_file_R1: got %h exp aaaa", a_rf[1]); end
        checks++; if (a_rf[2] !== 16'h5555) begin errors++; $display("FAIL rr_file_R2: got %h exp 5555", a_rf[2]); end
        tick();
    endtask

    task automatic test_fixed_prio();
        b_alu_req = 1; b_alu_reg = 4'd1; b_alu_data = 16'hAAAA;
        b_mem_req = 1; b_mem_reg = 4'd2; b_mem_data = 16'h5555;
        #1;
        checks++; if ({b_alu_gnt, b_mem_gnt} !== 2'b01) begin errors++; $display("FAIL fp_gnt0: got %b exp 01", {b_alu_gnt, b_mem_gnt}); end
        checks++; if (b_rf_dst !== 4'd2) begin errors++; $display("FAIL fp_dst0: got %0d exp 2", b_rf_dst); end
        tick();
        b_mem_req = 0;
        #1;
        checks++; if ({b_alu_gnt, b_mem_gnt} !== 2'b10) begin errors++; $display("FAIL fp_gnt1: got %b exp 10", {b_alu_gnt, b_mem_gnt}); end
        checks++; if (b_rf_dst !== 4'd1) begin errors++; $display("FAIL fp_dst1: got %0d exp 1", b_rf_dst); end
        tick();
        b_alu_req = 0;
        #1;
        checks++; if (b_rf[1] !== 16'hAAAA) begin errors++; $display("FAIL fp_file_R1: got %h exp aaaa", b_rf[1]); end
        checks++; if (b_rf[2] !== 16'h5555) begin errors++; $display("FAIL fp_file_R2: got %h exp 5555", b_rf[2]); end
        tick();
    endtask

    task automatic test_hazard();
        a_issue_valid = 1; a_issue_reg = 4'd5; a_src1 = 0; a_src2 = 0;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL hz_issue_free: got %b exp 0", a_stall); end
        tick();
        a_issue_valid = 0; a_src1 = 4'd5;
        #1;
        checks++; if (a_pending !== 16'h0020) begin errors++; $display("FAIL hz_pend_set: got %h exp 0020", a_pending); end
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL hz_raw_stall: got %b exp 1", a_stall); end
        a_mem_req = 1; a_mem_reg = 4'd5; a_mem_data = 16'h0055;
        #1;
        checks++; if (a_mem_gnt !== 1'b1) begin errors++; $display("FAIL hz_mem_gnt: got %b exp 1", a_mem_gnt); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL hz_bypass: got %b exp 0", a_stall); end
        tick();
        a_mem_req = 0;
        #1;
        checks++; if (a_pending !== 16'h0000) begin errors++; $display("FAIL hz_pend_clr: got %h exp 0000", a_pending); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL hz_after_clr: got %b exp 0", a_stall); end
        a_src1 = 0; a_issue_valid = 1; a_issue_reg = 4'd5;
        tick();
        a_mem_req = 1; a_mem_reg = 4'd5; a_mem_data = 16'h0066;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL hz_waw_bypass: got %b exp 0", a_stall); end
        checks++; if (a_mem_gnt !== 1'b1) begin errors++; $display("FAIL hz_mem_gnt2: got %b exp 1", a_mem_gnt); end
        tick();
        a_mem_req = 0;
        #1;
        checks++; if (a_pending !== 16'h0020) begin errors++; $display("FAIL hz_set_wins: got %h exp 0020", a_pending); end
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL hz_waw_stall: got %b exp 1", a_stall); end
        a_issue_valid = 0;
        tick();
    endtask

    task automatic test_init_restart();
        a_issue_valid = 1; a_issue_reg = 4'd7;
        tick();
        a_issue_valid = 0;
        #1;
        checks++; if (a_pending !== 16'h00A0) begin errors++; $display("FAIL ir_pend: got %h exp 00a0", a_pending); end
        a_alu_req = 1; a_alu_reg = 4'd9; a_alu_data = 16'h9999; a_init_start = 1;
        #1;
        checks++; if (a_alu_gnt !== 1'b0) begin errors++; $display("FAIL ir_gnt_forced: got %b exp 0", a_alu_gnt); end
        checks++; if (a_rf_we !== 1'b0) begin errors++; $display("FAIL ir_we_forced: got %b exp 0", a_rf_we); end
        tick();
        for (int i = 0; i < 16; i++) begin
            a_init_start = (i == 5);
            #1;
            checks++; if (a_pending !== 16'h0000) begin errors++; $display("FAIL ir_pend_clr[%0d]: got %h exp 0000", i, a_pending); end
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL ir_busy[%0d]: got %b exp 1", i, a_busy); end
            checks++; if (a_alu_gnt !== 1'b0) begin errors++; $display("FAIL ir_gnt[%0d]: got %b exp 0", i, a_alu_gnt); end
            checks++; if (a_rf_dst !== 4'(i)) begin errors++; $display("FAIL ir_dst[%0d]: got %0d exp %0d", i, a_rf_dst, i); end
            tick();
        end
        a_init_start = 0;
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL ir_done: got %b exp 0", a_busy); end
        checks++; if (a_alu_gnt !== 1'b1) begin errors++; $display("FAIL ir_gnt_after: got %b exp 1", a_alu_gnt); end
        checks++; if (a_rf_dst !== 4'd9) begin errors++; $display("FAIL ir_dst_after: got %0d exp 9", a_rf_dst); end
        tick();
        a_alu_req = 0;
        #1;
        checks++; if (a_rf[9] !== 16'h9999) begin errors++; $display("FAIL ir_file_R9: got %h exp 9999", a_rf[9]); end
        checks++; if (a_rf[5] !== 16'h0000) begin errors++; $display("FAIL ir_file_R5: got %h exp 0000", a_rf[5]); end
        tick();
    endtask

    task automatic test_r0_protect();
        b_mem_req = 1; b_mem_reg = 4'd0; b_mem_data = 16'hFFFF;
        a_mem_req = 1; a_mem_reg = 4'd0; a_mem_data = 16'hFFFF;
        #1;
        checks++; if (b_mem_gnt !== 1'b1) begin errors++; $display("FAIL r0_gnt: got %b exp 1", b_mem_gnt); end
        checks++; if (b_rf_we !== 1'b0) begin errors++; $display("FAIL r0_we: got %b exp 0", b_rf_we); end
        checks++; if (a_rf_we !== 1'b1) begin errors++; $display("FAIL r0_we_writable: got %b exp 1", a_rf_we); end
        tick();
        b_mem_req = 0; a_mem_req = 0;
        #1;
        checks++; if (b_rf[0] !== 16'h0000) begin errors++; $display("FAIL r0_file: got %h exp 0000", b_rf[0]); end
        checks++; if (a_rf[0] !== 16'hFFFF) begin errors++; $display("FAIL r0_file_writable: got %h exp ffff", a_rf[0]); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_rr_arb();
        test_fixed_prio();
        test_hazard();
        test_init_restart();
        test_r0_protect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
